// File: rtl/timestamp_local_ser.sv
// timestamp_local_ser
// Per-channel local real-time clock (seconds + microseconds) and timestamp
// serializer. Each rising edge of the frame trigger snapshots the live time
// and sends it as an 8-byte message: a one-cycle strobe, then eight bytes.
//
// Ports:
//   mclk, rst_n       clock (posedge) and asynchronous active-low reset
//   en                serializer enable; low aborts the message, clears pending/overrun
//   set_stb           load set_sec/set_usec into the counters this cycle
//   set_sec, set_usec time value to load
//   trig              frame trigger level; a rising edge is a timestamp event
//   clr_overrun       clears the sticky overrun flag
//   sec, usec         live counters
//   ts_stb            one-cycle pulse, one clock before the first message byte
//   ts_data           message byte, 0 when not sending
//   busy              message in progress (STB or SHIFT)
//   overrun           sticky: a trigger event was dropped
//   dbg_state         current serializer state (0 IDLE, 1 STB, 2 SHIFT)
//
// Stream protocol: there is no back-pressure. ts_stb marks the start of a
// message; the eight bytes follow on the next eight consecutive cycles
// (sec LSB first, then usec LSB first, last byte 0). All outputs registered.
module timestamp_local_ser #(
   parameter int CLK_PER_USEC = 100,
   parameter int USEC_MAX     = 999999
) (
   input  logic        mclk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        set_stb,
   input  logic [31:0] set_sec,
   input  logic [19:0] set_usec,
   input  logic        trig,
   input  logic        clr_overrun,
   output logic [31:0] sec,
   output logic [19:0] usec,
   output logic        ts_stb,
   output logic [7:0]  ts_data,
   output logic        busy,
   output logic        overrun,
   output logic [1:0]  dbg_state
);

   localparam int              PW         = $clog2(CLK_PER_USEC);
   localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_USEC - 1);
   localparam logic [19:0]     USEC_LAST  = 20'(USEC_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STB   = 2'd1,
      S_SHIFT = 2'd2
   } state_t;

   // time counters
   logic [PW-1:0] r_presc;
   logic [31:0]   r_sec;
   logic [19:0]   r_usec;

   // serializer state
   state_t        r_state;
   logic [2:0]    r_idx;
   logic [31:0]   r_act_sec;
   logic [19:0]   r_act_usec;
   logic [31:0]   r_pnd_sec;
   logic [19:0]   r_pnd_usec;
   logic          r_pending;
   logic          r_overrun;
   logic          r_trig_d;
   logic          r_ts_stb;
   logic [7:0]    r_ts_data;
   logic          r_busy;

   // next-state values
   state_t        w_state_nxt;
   logic [2:0]    w_idx_nxt;
   logic [31:0]   w_act_sec_nxt;
   logic [19:0]   w_act_usec_nxt;
   logic [31:0]   w_pnd_sec_nxt;
   logic [19:0]   w_pnd_usec_nxt;
   logic          w_pending_nxt;
   logic          w_overrun_nxt;
   logic          w_drop;
   logic          w_ev;
   logic          w_ts_stb_nxt;
   logic [7:0]    w_ts_data_nxt;
   logic          w_busy_nxt;

   function automatic logic [7:0] f_msg_byte(input logic [31:0] s,
                                             input logic [19:0] u,
                                             input logic [2:0]  i);
      logic [7:0] b;
      case (i)
         3'd0:    b = s[7:0];
         3'd1:    b = s[15:8];
         3'd2:    b = s[23:16];
         3'd3:    b = s[31:24];
         3'd4:    b = u[7:0];
         3'd5:    b = u[15:8];
         3'd6:    b = {4'b0000, u[19:16]};
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign w_ev = en & trig & ~r_trig_d;

   // ------------------------------------------------------------------
   // Real-time counters; a load overrides the increment of that cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_sec   <= '0;
         r_usec  <= '0;
      end else if (set_stb) begin
         r_presc <= '0;
         r_sec   <= set_sec;
         r_usec  <= set_usec;
      end else if (r_presc == PRESC_LAST) begin
         r_presc <= '0;
         if (r_usec == USEC_LAST) begin
            r_usec <= '0;
            r_sec  <= r_sec + 32'd1;
         end else begin
            r_usec <= r_usec + 20'd1;
         end
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Serializer state register
   // ------------------------------------------------------------------
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_act_sec  <= '0;
         r_act_usec <= '0;
         r_pnd_sec  <= '0;
         r_pnd_usec <= '0;
         r_pending  <= 1'b0;
         r_overrun  <= 1'b0;
         r_trig_d   <= 1'b0;
         r_ts_stb   <= 1'b0;
         r_ts_data  <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_act_sec  <= w_act_sec_nxt;
         r_act_usec <= w_act_usec_nxt;
         r_pnd_sec  <= w_pnd_sec_nxt;
         r_pnd_usec <= w_pnd_usec_nxt;
         r_pending  <= w_pending_nxt;
         r_overrun  <= w_overrun_nxt;
         r_trig_d   <= trig;
         r_ts_stb   <= w_ts_stb_nxt;
         r_ts_data  <= w_ts_data_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Serializer next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_act_sec_nxt  = r_act_sec;
      w_act_usec_nxt = r_act_usec;
      w_pnd_sec_nxt  = r_pnd_sec;
      w_pnd_usec_nxt = r_pnd_usec;
      w_pending_nxt  = r_pending;
      w_overrun_nxt  = r_overrun;
      w_drop         = 1'b0;

      if (!en) begin
         w_state_nxt   = S_IDLE;
         w_idx_nxt     = '0;
         w_pending_nxt = 1'b0;
         w_overrun_nxt = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_ev) begin
                  w_act_sec_nxt  = r_sec;
                  w_act_usec_nxt = r_usec;
                  w_state_nxt    = S_STB;
               end
            end
            S_STB: begin
               w_state_nxt = S_SHIFT;
               w_idx_nxt   = '0;
               if (w_ev) begin
                  if (!r_pending) begin
                     w_pnd_sec_nxt  = r_sec;
                     w_pnd_usec_nxt = r_usec;
                     w_pending_nxt  = 1'b1;
                  end else begin
                     w_drop = 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               if (r_idx == 3'd7) begin
                  if (r_pending) begin
                     // pending slot still occupied this cycle, so a new
                     // event here has nowhere to go
                     w_act_sec_nxt  = r_pnd_sec;
                     w_act_usec_nxt = r_pnd_usec;
                     w_pending_nxt  = 1'b0;
                     w_state_nxt    = S_STB;
                     w_drop         = w_ev;
                  end else if (w_ev) begin
                     // event on the last byte: capture and serve it at once
                     // instead of parking it in the pending slot
                     w_act_sec_nxt  = r_sec;
                     w_act_usec_nxt = r_usec;
                     w_state_nxt    = S_STB;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
                  if (w_ev) begin
                     if (!r_pending) begin
                        w_pnd_sec_nxt  = r_sec;
                        w_pnd_usec_nxt = r_usec;
                        w_pending_nxt  = 1'b1;
                     end else begin
                        w_drop = 1'b1;
                     end
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase

         // a drop in the same cycle as a clear leaves the flag set
         if (clr_overrun) w_overrun_nxt = 1'b0;
         if (w_drop)      w_overrun_nxt = 1'b1;
      end

      w_ts_stb_nxt  = (w_state_nxt == S_STB);
      w_busy_nxt    = (w_state_nxt != S_IDLE);
      w_ts_data_nxt = (w_state_nxt == S_SHIFT) ?
                      f_msg_byte(w_act_sec_nxt, w_act_usec_nxt, w_idx_nxt) : 8'h00;
   end

   assign sec       = r_sec;
   assign usec      = r_usec;
   assign ts_stb    = r_ts_stb;
   assign ts_data   = r_ts_data;
   assign busy      = r_busy;
   assign overrun   = r_overrun;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_timestamp_local_ser.sv
// Testbench for timestamp_local_ser: directed stimulus, a time-based model
// of message scheduling, and a per-cycle compare against that model.
module tb_timestamp_local_ser;

   localparam int     CPU  = 4;
   localparam int     UMAX = 999999;
   localparam longint UMOD = longint'(UMAX) + 1;
   localparam longint TMOD = 64'd4294967296 * UMOD;

   // ---------------- clock / reset ----------------
   logic        mclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic        set_stb = 1'b0;
   logic [31:0] set_sec = '0;
   logic [19:0] set_usec = '0;
   logic        trig = 1'b0;
   logic        clr_overrun = 1'b0;
   logic [31:0] sec;
   logic [19:0] usec;
   logic        ts_stb;
   logic [7:0]  ts_data;
   logic        busy;
   logic        overrun;
   logic [1:0]  dbg_state;

   always #5 mclk = ~mclk;

   timestamp_local_ser #(.CLK_PER_USEC(CPU), .USEC_MAX(UMAX)) dut (
      .mclk(mclk), .rst_n(rst_n), .en(en), .set_stb(set_stb),
      .set_sec(set_sec), .set_usec(set_usec), .trig(trig),
      .clr_overrun(clr_overrun), .sec(sec), .usec(usec), .ts_stb(ts_stb),
      .ts_data(ts_data), .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int stb_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Time is one number of microseconds since 0:0; messages are a schedule
   // of start cycles (strobe cycle) with their 64-bit payloads.
   longint      cyc = 0;
   longint      m_total = 0;
   int          m_cnt = 0;
   logic        m_trig_d = 1'b0;
   logic        m_ev = 1'b0;
   logic        m_ovr = 1'b0;
   longint      st_q[$];
   logic [63:0] exp_q[$];
   logic        e_stb = 1'b0;
   logic [7:0]  e_data = 8'h00;
   logic        e_busy = 1'b0;

   function automatic logic [31:0] m_sec(input longint t);
      return 32'(t / UMOD);
   endfunction
   function automatic logic [19:0] m_usec(input longint t);
      return 20'(t % UMOD);
   endfunction

   always @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         m_total = 0; m_cnt = 0; m_trig_d = 1'b0; m_ovr = 1'b0;
         st_q.delete(); exp_q.delete();
         e_stb = 1'b0; e_data = 8'h00; e_busy = 1'b0;
      end else begin
         cyc++;
         // keep messages that occupied the previous cycle or later
         while (st_q.size() > 0 && st_q[0] + 8 < cyc - 1) begin
            void'(st_q.pop_front());
            void'(exp_q.pop_front());
         end
         m_ev = en && trig && !m_trig_d;
         if (!en) begin
            st_q.delete(); exp_q.delete(); m_ovr = 1'b0;
         end else begin
            if (clr_overrun) m_ovr = 1'b0;
            if (m_ev) begin
               if (st_q.size() == 0) begin
                  st_q.push_back(cyc);
                  exp_q.push_back({8'h00, 4'h0, m_usec(m_total), m_sec(m_total)});
               end else if (st_q.size() == 1) begin
                  st_q.push_back(st_q[0] + 9);
                  exp_q.push_back({8'h00, 4'h0, m_usec(m_total), m_sec(m_total)});
               end else begin
                  m_ovr = 1'b1;
               end
            end
         end
         m_trig_d = trig;
         if (set_stb) begin
            m_total = longint'(set_sec) * UMOD + longint'(set_usec);
            m_cnt = 0;
         end else begin
            m_cnt++;
            if (m_cnt % CPU == 0) begin
               m_total++;
               if (m_total == TMOD) m_total = 0;
            end
         end
         e_stb = 1'b0; e_data = 8'h00; e_busy = 1'b0;
         foreach (st_q[i]) begin
            if (cyc >= st_q[i] && cyc <= st_q[i] + 8) begin
               e_busy = 1'b1;
               if (cyc == st_q[i]) e_stb = 1'b1;
               else e_data = 8'(exp_q[i] >> (8 * int'(cyc - st_q[i] - 1)));
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge mclk) begin
      chk("sec", 64'(sec), 64'(m_sec(m_total)));
      chk("usec", 64'(usec), 64'(m_usec(m_total)));
      chk("ts_stb", 64'(ts_stb), 64'(e_stb));
      chk("ts_data", 64'(ts_data), 64'(e_data));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("overrun", 64'(overrun), 64'(m_ovr));
      if (ts_stb === 1'b1) stb_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge mclk);
         #1;
      end
   endtask

   task automatic set_time(input logic [31:0] s, input logic [19:0] u);
      set_sec = s; set_usec = u; set_stb = 1'b1;
      tick(1);
      set_stb = 1'b0;
   endtask

   task automatic pulse_trig();
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int base;
      logic [7:0] exp_b [8];
      int gaps [8];
      exp_b = '{8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h21, 8'h43, 8'h05, 8'h00};
      gaps  = '{9, 8, 2, 3, 12, 4, 9, 7};

      // reset values
      tick(3);
      chk("rst_sec", 64'(sec), 64'h0);
      chk("rst_usec", 64'(usec), 64'h0);
      chk("rst_stb", 64'(ts_stb), 64'h0);
      chk("rst_data", 64'(ts_data), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_ovr", 64'(overrun), 64'h0);
      rst_n = 1'b1;
      tick(2);

      // microsecond wrap into seconds after 8 clocks
      set_time(32'h12345678, 20'd999998);
      tick(7);
      chk("pre_wrap_usec", 64'(usec), 64'd999999);
      chk("pre_wrap_sec", 64'(sec), 64'h12345678);
      tick(1);
      chk("wrap_usec", 64'(usec), 64'd0);
      chk("wrap_sec", 64'(sec), 64'h12345679);

      // single message, literal bytes
      set_time(32'h0A0B0C0D, 20'h54321);
      trig = 1'b1;
      tick(1);
      chk("msg_stb", 64'(ts_stb), 64'h1);
      chk("msg_stb_data", 64'(ts_data), 64'h0);
      chk("msg_stb_busy", 64'(busy), 64'h1);
      for (int k = 0; k < 8; k++) begin
         tick(1);
         chk("msg_byte", 64'(ts_data), 64'(exp_b[k]));
         chk("msg_busy", 64'(busy), 64'h1);
         chk("msg_nostb", 64'(ts_stb), 64'h0);
      end
      tick(1);
      chk("msg_end_data", 64'(ts_data), 64'h0);
      chk("msg_end_busy", 64'(busy), 64'h0);
      trig = 1'b0;
      tick(3);

      // two rises three cycles apart: second message right after the first
      base = stb_cnt;
      set_time(32'h11223344, 20'h000F0);
      tick(2);
      trig = 1'b1;
      tick(1);
      chk("two_stb1", 64'(ts_stb), 64'h1);
      trig = 1'b0;
      tick(2);
      pulse_trig();
      tick(6);
      chk("two_stb2", 64'(ts_stb), 64'h1);
      tick(5);
      chk("two_b4", 64'(ts_data), 64'hF1);
      tick(6);
      chk("two_busy", 64'(busy), 64'h0);
      chk("two_ovr", 64'(overrun), 64'h0);
      chk("two_msgs", 64'(stb_cnt - base), 64'd2);

      // three rises inside one message: third dropped, overrun sticky
      base = stb_cnt;
      pulse_trig();
      tick(1);
      pulse_trig();
      tick(1);
      pulse_trig();
      tick(20);
      chk("three_ovr", 64'(overrun), 64'h1);
      tick(5);
      chk("three_ovr_sticky", 64'(overrun), 64'h1);
      clr_overrun = 1'b1;
      tick(1);
      clr_overrun = 1'b0;
      chk("three_ovr_clr", 64'(overrun), 64'h0);
      chk("three_msgs", 64'(stb_cnt - base), 64'd2);

      // trig held high: one message only
      base = stb_cnt;
      trig = 1'b1;
      tick(50);
      trig = 1'b0;
      tick(12);
      chk("held_msgs", 64'(stb_cnt - base), 64'd1);

      // en dropped while b3 is on the bus
      base = stb_cnt;
      trig = 1'b1;
      tick(5);
      en = 1'b0;
      trig = 1'b0;
      tick(1);
      chk("en_data", 64'(ts_data), 64'h0);
      chk("en_busy", 64'(busy), 64'h0);
      tick(15);
      en = 1'b1;
      tick(10);
      chk("en_msgs", 64'(stb_cnt - base), 64'd1);

      // asynchronous reset while b5 is on the bus
      trig = 1'b1;
      tick(7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_stb", 64'(ts_stb), 64'h0);
      chk("arst_data", 64'(ts_data), 64'h0);
      chk("arst_busy", 64'(busy), 64'h0);
      chk("arst_sec", 64'(sec), 64'h0);
      chk("arst_usec", 64'(usec), 64'h0);
      trig = 1'b0;
      base = stb_cnt;
      tick(2);
      rst_n = 1'b1;
      tick(20);
      chk("arst_msgs", 64'(stb_cnt - base), 64'd0);

      // full wrap of seconds and microseconds
      set_time(32'hFFFFFFFF, 20'(UMAX));
      tick(3);
      chk("full_pre_sec", 64'(sec), 64'hFFFFFFFF);
      tick(1);
      chk("full_sec", 64'(sec), 64'h0);
      chk("full_usec", 64'(usec), 64'h0);

      // trigger spacing table, checked by the per-cycle compare
      for (int i = 0; i < 8; i++) begin
         clr_overrun = (i == 4);
         pulse_trig();
         tick(gaps[i] - 1);
      end
      clr_overrun = 1'b0;
      tick(25);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
